// File: rtl/axis_packetizer.sv
// axis_packetizer: frames an unframed AXI-stream into TSTART/TLAST packets behind an output FIFO
// Optional AXIS_PACKETIZER_ABORT_PAD_EN: ABORT in FILL closes the open packet with TSTRB=0 pad beats instead of truncating it.
module axis_packetizer #(
  parameter int AXIS_WIDTH_DATA = 32,
  parameter int AXIS_WIDTH_DS   = AXIS_WIDTH_DATA / 8,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                       AXIS_CLK,
  input  logic                       ARESET,
  input  logic                       CFG_GO,
  input  logic                       CFG_ABORT,
  input  logic [15:0]                CFG_PACKET,
  input  logic [31:0]                CFG_FRAME,
  input  logic                       S_TVALID,
  output logic                       S_TREADY,
  input  logic [AXIS_WIDTH_DATA-1:0] S_TDATA,
  output logic                       M_TVALID,
  input  logic                       M_TREADY,
  output logic [AXIS_WIDTH_DATA-1:0] M_TDATA,
  output logic [AXIS_WIDTH_DS-1:0]   M_TSTRB,
  output logic                       M_TLAST,
  output logic                       M_TSTART,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       ERR
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(AXIS_WIDTH_DS);
  localparam int EW = AXIS_WIDTH_DATA + 3;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
`ifdef AXIS_PACKETIZER_ABORT_PAD_EN
  localparam state_t ABORT_ST = DRAIN;
`else
  localparam state_t ABORT_ST = IDLE;
`endif
  state_t state, state_nx;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [15:0] pkt_beats, bip, pk_div;
  logic [31:0] frame, byte_cnt;
  logic full, empty, s_acc, pop, push, pad_push, pad_pend, flush, abort_hit;
  logic go_ok, cfg_bad, pkt_end, frame_end, final_pop;
  assign head = mem[rd_ptr];
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign S_TREADY = state == FILL && !full;
  assign s_acc = S_TVALID && S_TREADY;
  assign M_TVALID = !empty;
  assign pop = M_TVALID && M_TREADY;
  assign M_TDATA = empty ? '0 : head[AXIS_WIDTH_DATA-1:0];
  assign M_TSTART = !empty && head[AXIS_WIDTH_DATA];
  assign M_TLAST = !empty && head[AXIS_WIDTH_DATA+1];
  assign M_TSTRB = (empty || head[AXIS_WIDTH_DATA+2]) ? '0 : '1;
  assign BUSY = state != IDLE;
  assign pk_div = CFG_PACKET == '0 ? 16'd1 : CFG_PACKET;
  assign cfg_bad = CFG_PACKET == '0 || CFG_PACKET[SW-1:0] != '0 || CFG_FRAME == '0 ||
                   CFG_FRAME % {16'd0, pk_div} != '0;
  assign go_ok = state == IDLE && CFG_GO && !CFG_ABORT;
  assign pkt_end = bip == pkt_beats - 16'd1;
  assign frame_end = s_acc && byte_cnt + 32'(AXIS_WIDTH_DS) == frame;
`ifdef AXIS_PACKETIZER_ABORT_PAD_EN
  assign abort_hit = state == FILL && CFG_ABORT;
  assign flush = 1'b0;
  assign pad_push = state == DRAIN && pad_pend && !full;
`else
  assign abort_hit = state != IDLE && CFG_ABORT;
  assign flush = abort_hit;
  assign pad_push = 1'b0;
  assign pad_pend = 1'b0;
`endif
  assign push = s_acc || pad_push;
  assign final_pop = state == DRAIN && !pad_pend && (empty || (count == (AW+1)'(1) && pop));
  // next state: completion beats abort, abort beats frame end and GO
  always_comb begin
    state_nx = final_pop ? IDLE :
               abort_hit ? ABORT_ST :
               (state == FILL && frame_end) ? DRAIN :
               (go_ok && !cfg_bad) ? FILL : state;
  end
  // state register
  always_ff @(posedge AXIS_CLK) begin
    if (ARESET) state <= IDLE;
    else state <= state_nx;
  end
  // FIFO storage as {pad, last, start, data}; contents only matter once written
  always_ff @(posedge AXIS_CLK) begin
    if (push) mem[wr_ptr] <= {pad_push, pkt_end, bip == '0, pad_push ? {AXIS_WIDTH_DATA{1'b0}} : S_TDATA};
  end
  // config latch, frame/packet counters, FIFO pointers and status pulses
  always_ff @(posedge AXIS_CLK) begin
    if (ARESET) begin
      {ERR, DONE, wr_ptr, rd_ptr, count} <= '0;
      {pkt_beats, bip, frame, byte_cnt} <= '0;
    end else begin
      ERR <= go_ok && cfg_bad;
      DONE <= final_pop && !flush;
      if (go_ok) begin
        pkt_beats <= CFG_PACKET >> SW;
        frame <= CFG_FRAME;
        byte_cnt <= '0;
        bip <= '0;
      end
      if (s_acc) byte_cnt <= byte_cnt + 32'(AXIS_WIDTH_DS);
      if (push) bip <= pkt_end ? '0 : bip + 16'd1;
      if (flush) begin
        {wr_ptr, rd_ptr, count} <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(pop);
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
`ifdef AXIS_PACKETIZER_ABORT_PAD_EN
  // pad request: raised by ABORT mid-packet, dropped once the closing pad beat is queued
  always_ff @(posedge AXIS_CLK) begin
    if (ARESET) pad_pend <= 1'b0;
    else if (abort_hit) pad_pend <= s_acc ? !pkt_end : bip != '0;
    else if (pad_push && pkt_end) pad_pend <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_axis_packetizer.sv
// tb_axis_packetizer: directed table-driven bench for axis_packetizer
module tb_axis_packetizer;
  logic clk = 1'b0;
  logic rst, go, abort, s_tvalid, s_tready, m_tvalid, m_tready, m_tlast, m_tstart, busy, done, err;
  logic [15:0] packet;
  logic [31:0] frame, s_tdata, m_tdata;
  logic [3:0] m_tstrb;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [15:0] pkt;
    logic [31:0] frm;
    logic        err;
    int          mode;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  axis_packetizer dut (
    .AXIS_CLK(clk), .ARESET(rst), .CFG_GO(go), .CFG_ABORT(abort),
    .CFG_PACKET(packet), .CFG_FRAME(frame),
    .S_TVALID(s_tvalid), .S_TREADY(s_tready), .S_TDATA(s_tdata),
    .M_TVALID(m_tvalid), .M_TREADY(m_tready), .M_TDATA(m_tdata), .M_TSTRB(m_tstrb),
    .M_TLAST(m_tlast), .M_TSTART(m_tstart), .BUSY(busy), .DONE(done), .ERR(err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_m_tvalid"}, m_tvalid, 0);
    check({tag, "_s_tready"}, s_tready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_m_fields"}, {m_tdata, m_tstrb, m_tlast, m_tstart}, 0);
  endtask

  task automatic pulse_go(input logic [15:0] p, input logic [31:0] f, input logic exp_err);
    @(negedge clk);
    packet = p; frame = f; go = 1; abort = 0;
    @(negedge clk);
    go = 0;
    check("go_err", err, exp_err);
    check("go_busy", busy, !exp_err);
    if (exp_err) begin
      check("go_bad_s_tready", s_tready, 0);
      @(negedge clk);
      check("err_pulse_width", err, 0);
      check("err_busy_stays_low", busy, 0);
    end
  endtask

  // mode 0: full rate, 1: random 50% on both sides, 2: sink stalled for 30 cycles
  task automatic run_frame(input logic [15:0] p, input logic [31:0] f, input int mode, input logic [31:0] base);
    int nb, pb, in_i, out_i, cyc, dn_early, dn;
    logic hold, sv, mr;
    logic [38:0] saved;
    nb = int'(f) / 4; pb = int'(p) / 4;
    in_i = 0; out_i = 0; cyc = 0; dn_early = 0; dn = 0; hold = 0; saved = '0;
    while (out_i < nb && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (hold) check("hold_stable", {m_tvalid, m_tdata, m_tstrb, m_tlast, m_tstart}, saved);
      if (done) dn_early++;
      if (mode == 2 && cyc == 30) begin
        check("stall_accepted", in_i, 16);
        check("stall_s_tready", s_tready, 0);
      end
      sv = in_i < nb && (mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1);
      mr = mode == 1 ? 1'($urandom_range(0, 1)) : mode == 2 ? cyc > 30 : 1'b1;
      s_tvalid = sv; s_tdata = base + 32'(in_i); m_tready = mr;
      if (sv && s_tready) in_i++;
      if (m_tvalid && mr) begin
        check("beat_data", m_tdata, base + 32'(out_i));
        check("beat_strb", m_tstrb, 4'hF);
        check("beat_start", m_tstart, (out_i % pb) == 0);
        check("beat_last", m_tlast, (out_i % pb) == pb - 1);
        out_i++;
      end
      hold = m_tvalid && !mr;
      saved = {m_tvalid, m_tdata, m_tstrb, m_tlast, m_tstart};
    end
    check("frame_beats", out_i, nb);
    check("frame_inputs", in_i, nb);
    check("done_early", dn_early, 0);
    s_tvalid = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("done_once", dn, 1);
    check("busy_after", busy, 0);
    check("m_tvalid_after", m_tvalid, 0);
  endtask

  initial begin
    logic [31:0] outd[32];
    logic [3:0]  outs[32];
    logic        outl[32], outst[32];
    int in_i, nout, dn, ab_c, gop;
    logic ab;
    vecs[0] = '{16'h40, 32'h400, 1'b0, 0};
    vecs[1] = '{16'h40, 32'h400, 1'b0, 1};
    vecs[2] = '{16'h40, 32'h100, 1'b0, 2};
    vecs[3] = '{16'h42, 32'h400, 1'b1, 0};
    vecs[4] = '{16'h00, 32'h400, 1'b1, 0};
    vecs[5] = '{16'h40, 32'h000, 1'b1, 0};
    vecs[6] = '{16'h40, 32'h060, 1'b1, 0};
    vecs[7] = '{16'h04, 32'h010, 1'b0, 1};
    rst = 1; go = 0; abort = 0; packet = 0; frame = 0; s_tvalid = 0; s_tdata = 0; m_tready = 0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 0;

    for (int i = 0; i < 8; i++) begin
      pulse_go(vecs[i].pkt, vecs[i].frm, vecs[i].err);
      if (!vecs[i].err) run_frame(vecs[i].pkt, vecs[i].frm, vecs[i].mode, 32'h1000 * (i + 1));
    end

    // ABORT after the fifth input beat of the first packet
    pulse_go(16'h40, 32'h400, 0);
    in_i = 0; nout = 0; dn = 0; ab = 0; ab_c = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (done) dn++;
`ifndef AXIS_PACKETIZER_ABORT_PAD_EN
      if (ab && c == ab_c + 1) begin
        check("abort_flush_m_tvalid", m_tvalid, 0);
        check("abort_busy", busy, 0);
        check("abort_s_tready", s_tready, 0);
      end
`endif
      abort = 0;
      if (in_i < 5) s_tvalid = 1;
      else begin
        s_tvalid = 0;
        if (!ab) begin abort = 1; ab = 1; ab_c = c; end
      end
      s_tdata = 32'hA00 + 32'(in_i); m_tready = 1;
      if (s_tvalid && s_tready) in_i++;
      if (m_tvalid) begin
        if (nout < 32) begin
          outd[nout] = m_tdata; outs[nout] = m_tstrb; outl[nout] = m_tlast; outst[nout] = m_tstart;
        end
        nout++;
      end
    end
    abort = 0;
`ifdef AXIS_PACKETIZER_ABORT_PAD_EN
    check("pad_nout", nout, 16);
    for (int k = 0; k < 16 && k < nout; k++) begin
      check("pad_data", outd[k], k < 5 ? 32'hA00 + 32'(k) : 32'h0);
      check("pad_strb", outs[k], k < 5 ? 4'hF : 4'h0);
      check("pad_last", outl[k], k == 15);
      check("pad_start", outst[k], k == 0);
    end
    check("pad_done", dn, 1);
`else
    check("abort_nout", nout, 5);
    for (int k = 0; k < 5 && k < nout; k++) begin
      check("abort_data", outd[k], 32'hA00 + 32'(k));
      check("abort_last", outl[k], 0);
      check("abort_start", outst[k], k == 0);
    end
    check("abort_done", dn, 0);
`endif
    check("abort_end_busy", busy, 0);
    check("abort_end_m_tvalid", m_tvalid, 0);

    // GO while busy is ignored, then ARESET at beat 100
    pulse_go(16'h40, 32'h400, 0);
    in_i = 0; gop = 0;
    for (int c = 0; c < 400 && in_i < 100; c++) begin
      @(negedge clk);
      if (gop == 1) begin
        check("go_busy_err", err, 0);
        check("go_busy_busy", busy, 1);
        gop = 2;
      end
      go = 0;
      if (in_i == 50 && gop == 0) begin go = 1; packet = 0; gop = 1; end
      s_tvalid = 1; s_tdata = 32'(in_i); m_tready = 1;
      if (s_tready) in_i++;
    end
    check("pre_reset_beats", in_i, 100);
    @(negedge clk);
    go = 0; s_tvalid = 0; rst = 1;
    @(negedge clk);
    check_idle("mid_reset");
    rst = 0;
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("mid_reset_no_done", dn, 0);
    pulse_go(16'h40, 32'h100, 0);
    run_frame(16'h40, 32'h100, 0, 32'hC000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
